// File: rtl/my_reset_sequencer.sv
// my_reset_sequencer
// Power-up and push-button reset sequencer. After the board reset `rst` is
// released, the downstream reset o_resetn is held low for HOLD_CYCLES edges.
// Optionally, a debounced board button re-asserts o_resetn. The reset is held
// while the button is pressed. After release, the full hold repeats.
//
// Configuration macro:
//   RESET_SEQ_BTN_EN - when defined, the button path is built.
//                      This covers the synchronizer, DEBOUNCE/ASSERT handling
//                      and the press counter. When undefined, i_btn is
//                      ignored, the FSM stays in RUN after POR, and
//                      o_btn_resets is tied to 0.
//
// Ports:
//   i_clk        - design clock, rising edge
//   rst          - synchronous active-low reset
//   i_btn        - raw asynchronous button, active-high
//   o_resetn     - registered active-low reset for downstream logic
//   o_state      - FSM state: 0 POR, 1 RUN, 2 DEBOUNCE, 3 ASSERT
//   o_btn_resets - accepted button resets, saturating at 255
module my_reset_sequencer #(
   parameter int unsigned HOLD_CYCLES     = 1200,
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic       i_clk,
   input  logic       rst,
   input  logic       i_btn,
   output logic       o_resetn,
   output logic [1:0] o_state,
   output logic [7:0] o_btn_resets
);

   localparam int unsigned MaxCycles = (HOLD_CYCLES > DEBOUNCE_CYCLES) ?
                                       HOLD_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StPor      = 2'd0,
      StRun      = 2'd1,
      StDebounce = 2'd2,
      StAssert   = 2'd3
   } state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_resetn;

`ifdef RESET_SEQ_BTN_EN
   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0] r_sync;
   logic [7:0] r_btn_resets;
   logic       w_btn_s;

   assign w_btn_s = r_sync[1];
`else
   // Button input is deliberately ignored in this build.
   logic w_unused_btn;
   assign w_unused_btn = i_btn;
`endif

   always_ff @(posedge i_clk) begin
      if (!rst) begin
         r_state  <= StPor;
         r_cnt    <= '0;
         r_resetn <= 1'b0;
`ifdef RESET_SEQ_BTN_EN
         r_sync       <= 2'b00;
         r_btn_resets <= 8'd0;
`endif
      end else begin
`ifdef RESET_SEQ_BTN_EN
         r_sync <= {r_sync[0], i_btn};
`endif
         case (r_state)
            StPor: begin
               if (r_cnt == HoldLast) begin
                  r_state  <= StRun;
                  r_cnt    <= '0;
                  r_resetn <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StRun: begin
`ifdef RESET_SEQ_BTN_EN
               if (w_btn_s) begin
                  r_state <= StDebounce;
                  r_cnt   <= '0;
               end
`endif
            end
`ifdef RESET_SEQ_BTN_EN
            StDebounce: begin
               if (!w_btn_s) begin
                  // Glitch: the press was too short, so it is dropped.
                  // o_resetn never moved.
                  r_state <= StRun;
                  r_cnt   <= '0;
               end else if (r_cnt == DebLast) begin
                  r_state  <= StAssert;
                  r_cnt    <= '0;
                  r_resetn <= 1'b0;
                  if (r_btn_resets != 8'hff) begin
                     r_btn_resets <= r_btn_resets + 8'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CntW'(1);
               end
            end
            StAssert: begin
               // Hold reset while pressed.
               // Release restarts the full POR hold.
               if (!w_btn_s) begin
                  r_state <= StPor;
                  r_cnt   <= '0;
               end
            end
`endif
            default: begin
               r_state  <= StPor;
               r_cnt    <= '0;
               r_resetn <= 1'b0;
            end
         endcase
      end
   end

   assign o_resetn = r_resetn;
   assign o_state  = r_state;
`ifdef RESET_SEQ_BTN_EN
   assign o_btn_resets = r_btn_resets;
`else
   assign o_btn_resets = 8'd0;
`endif

endmodule

// File: tb/tb_my_reset_sequencer.sv
// tb_my_reset_sequencer
// Randomized bench for my_reset_sequencer (HOLD_CYCLES=16, DEBOUNCE_CYCLES=8).
// The reference model tracks reset behaviour in terms of remaining hold
// edges, a "button-held reset active" flag, and the run length of
// consecutive synchronized button-high samples. It follows RESET_SEQ_BTN_EN
// the same way the design does.
module tb_my_reset_sequencer;

   localparam int unsigned Hold = 16;
   localparam int unsigned Deb  = 8;
`ifdef RESET_SEQ_BTN_EN
   localparam bit BtnEn = 1'b1;
`else
   localparam bit BtnEn = 1'b0;
`endif

   logic       i_clk;
   logic       rst;
   logic       i_btn;
   logic       o_resetn;
   logic [1:0] o_state;
   logic [7:0] o_btn_resets;

   my_reset_sequencer #(
      .HOLD_CYCLES    (Hold),
      .DEBOUNCE_CYCLES(Deb)
   ) dut (
      .i_clk       (i_clk),
      .rst         (rst),
      .i_btn       (i_btn),
      .o_resetn    (o_resetn),
      .o_state     (o_state),
      .o_btn_resets(o_btn_resets)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_cmp   = 0;
   int n_err   = 0;
   int n_cycle = 0;

   // Reference model state.
   logic [1:0] m_sync      = 2'b00;
   int         m_hold_left = Hold;
   bit         m_asserted  = 1'b0;
   int         m_run_high  = 0;
   int         m_count     = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, n_cycle, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst_v, input logic btn_v);
      logic bs;
      if (!rst_v) begin
         m_sync      = 2'b00;
         m_hold_left = Hold;
         m_asserted  = 1'b0;
         m_run_high  = 0;
         m_count     = 0;
      end else begin
         bs     = BtnEn ? m_sync[1] : 1'b0;
         m_sync = {m_sync[0], btn_v};
         if (m_asserted) begin
            if (!bs) begin
               m_asserted  = 1'b0;
               m_hold_left = Hold;
            end
         end else if (m_hold_left > 0) begin
            m_hold_left--;
         end else if (bs) begin
            // The first high sample opens the window.
            // Deb more samples accept the press.
            m_run_high++;
            if (m_run_high == Deb + 1) begin
               m_asserted = 1'b1;
               m_run_high = 0;
               if (m_count < 255) m_count++;
            end
         end else begin
            m_run_high = 0;
         end
      end
   endtask

   function automatic int exp_state();
      if (m_asserted) return 3;
      if (m_hold_left > 0) return 0;
      if (m_run_high > 0) return 2;
      return 1;
   endfunction

   function automatic int exp_resetn();
      return (m_asserted || m_hold_left > 0) ? 0 : 1;
   endfunction

   // Drive one cycle, advance the model on the edge, and compare just after.
   task automatic step(input logic rst_v, input logic btn_v);
      rst   = rst_v;
      i_btn = btn_v;
      @(posedge i_clk);
      n_cycle++;
      model_edge(rst_v, btn_v);
      #1;
      check_eq("resetn", int'(o_resetn), exp_resetn());
      check_eq("state", int'(o_state), exp_state());
      check_eq("btn_resets", int'(o_btn_resets), m_count);
   endtask

   initial begin
      int len;
      rst   = 1'b0;
      i_btn = 1'b0;

      // Power-up: o_resetn rises exactly on the 16th edge after release.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check_eq("por_state", int'(o_state), 0);
      check_eq("por_count", int'(o_btn_resets), 0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0);
         check_eq("por_hold", int'(o_resetn), (i < 16) ? 0 : 1);
      end
      check_eq("por_run", int'(o_state), 1);

      // Glitch shorter than the debounce window.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      check_eq("glitch_resetn", int'(o_resetn), 1);
      check_eq("glitch_count", int'(o_btn_resets), 0);

      // Valid press, then release and full hold.
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
      check_eq("press_resetn", int'(o_resetn), BtnEn ? 0 : 1);
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
      check_eq("press_count", int'(o_btn_resets), BtnEn ? 1 : 0);
      check_eq("press_back", int'(o_resetn), 1);

      // Reset while debouncing at count 5; the hold restarts from scratch.
      for (int i = 0; i < 30 && m_run_high != 6; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      check_eq("midrst_state", int'(o_state), 0);
      check_eq("midrst_count", int'(o_btn_resets), 0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0);
         check_eq("midrst_hold", int'(o_resetn), (i < 16) ? 0 : 1);
      end

      // Button held from power-up: POR ignores it, rise still at edge 16.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b1);
         if (i == 16) check_eq("held_rise", int'(o_resetn), 1);
      end
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0);

      // Saturation: 257 accepted presses with randomized press/gap lengths.
      step(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
      for (int p = 0; p < 257; p++) begin
         len = 10 + int'($urandom_range(0, 4));
         for (int i = 0; i < len; i++) step(1'b1, 1'b1);
         len = 20 + int'($urandom_range(0, 4));
         for (int i = 0; i < len; i++) step(1'b1, 1'b0);
      end
      check_eq("sat_count", int'(o_btn_resets), BtnEn ? 255 : 0);

      // Random traffic with occasional board resets.
      for (int b = 0; b < 150; b++) begin
         logic lvl;
         lvl = $urandom_range(0, 1) != 0;
         len = int'($urandom_range(1, 14));
         for (int i = 0; i < len; i++) begin
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0, lvl);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
